dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Parametrised direct-mapped, write-through, no-write-allocate data cache between the MIPS core
//  load/store port and the data memory. Single-cycle read hits; multi-word line refill on a read miss.
//  Write-through over a req/ack memory handshake. Stalls the core via cpu_ready.
//  Adds a flush input and saturating hit/miss counters so benches can measure cache behaviour.
// PARAMETERS
//  ADDR_W     32  byte-address width
//  DATA_W     32  word width; a multiple of 8, power of two
//  LINES      16  number of cache lines; power of two, >=2
//  WORDS      4   words per line; power of two, >=1
//  CNT_W      32  width of the hit/miss counters
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  cpu_req    in   1       access request; held until cpu_ready
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   ADDR_W  byte address; low log2(DATA_W/8) bits are ignored (word aligned)
//  cpu_wdata  in   DATA_W  store data
//  cpu_rdata  out  DATA_W  load data; valid when cpu_ready & cpu_req & !cpu_we
//  cpu_ready  out  1       access completes this cycle
//  flush      in   1       invalidate all lines; sampled only in IDLE
//  mem_req    out  1       memory request; held until mem_ack
//  mem_we     out  1       memory write
//  mem_addr   out  ADDR_W  word-aligned memory byte address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; valid with mem_ack
//  mem_ack    in   1       one-cycle completion pulse from memory
//  hit_cnt    out  CNT_W   read hits, saturating
//  miss_cnt   out  CNT_W   read misses, saturating
// BEHAVIOUR
//  Address split, LSB first: byte offset, word-in-line [log2 WORDS], index [log2 LINES], tag (rest).
//  Reset (async): state=IDLE; all valid bits=0; counters=0; mem_req=0; mem_we=0; cpu_ready=0;
//   mem_addr=0; mem_wdata=0; cpu_rdata=0. Data and tag arrays are not reset.
//  Reset asserted mid-refill or mid-write aborts the operation. The partially filled line stays invalid.
//  States:
//   IDLE   - no access in progress.
//   REFILL - fetching a line after a read miss.
//   WRITE  - a store is waiting for the memory ack.
//  IDLE:
//   - flush=1 (takes precedence over cpu_req): clear all valid bits. cpu_ready=0 that cycle. Stay IDLE.
//   - Read hit: cpu_ready=1 in the same cycle (combinational from the arrays). cpu_rdata = the cached
//     word. hit_cnt+1. Stay IDLE.
//   - Read miss: miss_cnt+1. Clear valid[index]. Latch the tag and index. Start at word 0. Go to REFILL.
//   - Write: latch addr/data. Assert mem_req/mem_we. Go to WRITE. On a hit, also update the cached word
//     now (no-write-allocate on a miss).
//  REFILL:
//   - Issue word k of the line: mem_addr = {tag, index, k, 0s}, mem_req=1, mem_we=0.
//   - On mem_ack: store mem_rdata into word k. Then either k+1, or (if k=WORDS-1) set valid and tag,
//     return to IDLE.
//   - Drop mem_req for exactly 1 cycle between words. Fetch words in order 0..WORDS-1.
//   - The held cpu_req re-evaluates in IDLE and hits. Total miss latency = WORDS*(ack latency+1)+1 cycles.
//  WRITE:
//   - Hold mem_req=1, mem_we=1, mem_addr and mem_wdata stable until mem_ack.
//   - On mem_ack: cpu_ready=1 that same cycle. Deassert mem_req next cycle. Return to IDLE.
//  Handshake rules:
//   - mem_ack is ignored when mem_req=0. Memory side never sees mem_req drop before mem_ack.
//   - cpu_ready is never asserted when cpu_req=0. cpu_* inputs must be stable while cpu_req && !cpu_ready.
//  Counters:
//   - Saturate at all-ones. Stores are not counted.
//   - flush=1 in IDLE with cpu_req=1 counts nothing that cycle.
// TESTING
//  1 Reset, read 0x4 with mem ack latency 2 -> miss_cnt=1, four reads 0x0,0x4,0x8,0xC; then ready with
//    rdata = mem[0x4]; hit_cnt=1.
//  2 Read 0x8 after test 1 -> cpu_ready same cycle, no mem_req, hit_cnt=2.
//  3 Store 0xDEADBEEF @0x4 (hit) -> mem write @0x4 held to ack; later read 0x4 hits = 0xDEADBEEF.
//  4 Store @0x100 (miss) -> one mem write, no refill; read 0x100 -> miss, refill of 0x100..0x10C.
//  5 Addresses 0x0 and LINES*WORDS*4 alternately -> every read misses (conflict); miss_cnt increments each.
//  6 flush in IDLE then read 0x4 -> miss. rst pulse mid-REFILL -> mem_req=0 immediately, counters=0,
//    next read of that line misses.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Core load/store port, data-memory port, flush control and hit/miss statistics of dcache_ctrl.
// The cache is the slave modport; the surrounding core/memory environment is the master.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill on read miss,
// flush, and saturating read hit/miss counters.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int WB    = $clog2(WORDS);
  localparam int WL    = (WB > 0) ? WB : 1;
  localparam int IB    = $clog2(LINES);
  localparam int TAG_W = ADDR_W - BOFF - WB - IB;
  localparam int ENT_W = IB + WB;
  localparam logic [WL-1:0] LAST_WORD = WL'(WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  function automatic logic [ENT_W-1:0] entry(input logic [IB-1:0] idx, input logic [WL-1:0] wd);
    entry = (ENT_W'(idx) << WB) | ENT_W'(wd);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IB-1:0] i, input logic [WL-1:0] w);
    word_addr = (ADDR_W'(t) << (BOFF + WB + IB)) | (ADDR_W'(i) << (BOFF + WB)) | (ADDR_W'(w) << BOFF);
  endfunction

  logic [DATA_W-1:0] data_q [LINES*WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];

  logic [1:0]        state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic [IB-1:0]     fill_idx_q, fill_idx_d;
  logic [WL-1:0]     fill_word_q, fill_word_d;

  logic [TAG_W-1:0]  a_tag;
  logic [IB-1:0]     a_idx;
  logic [WL-1:0]     a_word;
  logic              hit, rd_hit, cpu_ready, fill_we, store_we, line_done;

  assign a_word = WL'((bus.cpu_addr >> BOFF) & ADDR_W'(WORDS - 1));
  assign a_idx  = bus.cpu_addr[BOFF+WB +: IB];
  assign a_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_tag_d  = fill_tag_q;
    fill_idx_d  = fill_idx_q;
    fill_word_d = fill_word_q;
    rd_hit      = 1'b0;
    cpu_ready   = 1'b0;
    fill_we     = 1'b0;
    store_we    = 1'b0;
    line_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          valid_d = '0;
        end else if (bus.cpu_req && bus.cpu_we) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr(a_tag, a_idx, a_word);
          mem_wdata_d = bus.cpu_wdata;
          store_we    = hit;
          state_d     = S_WRITE;
        end else if (bus.cpu_req && hit) begin
          rd_hit    = 1'b1;
          cpu_ready = 1'b1;
          if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
        end else if (bus.cpu_req) begin
          if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
          valid_d[a_idx] = 1'b0;
          fill_tag_d     = a_tag;
          fill_idx_d     = a_idx;
          fill_word_d    = '0;
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b0;
          mem_addr_d     = word_addr(a_tag, a_idx, '0);
          state_d        = S_REFILL;
        end
      end
      S_REFILL: begin
        // mem_req low for one cycle after each ack separates consecutive word fetches.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (bus.mem_ack) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          if (fill_word_q == LAST_WORD) begin
            valid_d[fill_idx_q] = 1'b1;
            line_done           = 1'b1;
            state_d             = S_IDLE;
          end else begin
            fill_word_d = fill_word_q + 1'b1;
            mem_addr_d  = word_addr(fill_tag_q, fill_idx_q, fill_word_q + 1'b1);
          end
        end
      end
      S_WRITE: begin
        if (mem_req_q && bus.mem_ack) begin
          cpu_ready = bus.cpu_req;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_tag_q  <= '0;
      fill_idx_q  <= '0;
      fill_word_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_tag_q  <= fill_tag_d;
      fill_idx_q  <= fill_idx_d;
      fill_word_q <= fill_word_d;
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[entry(fill_idx_q, fill_word_q)] <= bus.mem_rdata;
    if (store_we)  data_q[entry(a_idx, a_word)]           <= bus.cpu_wdata;
    if (line_done) tag_q[fill_idx_q]                      <= fill_tag_q;
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = rd_hit ? data_q[entry(a_idx, a_word)] : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed cache scenarios plus random loads/stores/flushes
// checked against a tag-level cache model and a word-addressed memory model.
module tb_dcache_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int LINE_B = 4 * WORDS;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          cyc;
    int          hits;
    int          misses;
  } cpu_exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ack_lat = 2;

  mem_exp_t exp_mem[$];
  cpu_exp_t exp_cpu[$];

  bit          mvalid [LINES];
  int unsigned mtag   [LINES];
  int          mhits, mmiss;
  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] phys_mem [int unsigned];

  dcache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dcache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return ref_mem.exists(k) ? ref_mem[k] : mem_init(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return phys_mem.exists(k) ? phys_mem[k] : mem_init(a);
  endfunction

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    mhits = 0;
    mmiss = 0;
  endtask

  // One CPU access: predict the outcome from the model, queue expectations, then drive the port.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit fl, input int lat);
    cpu_exp_t    it;
    mem_exp_t    m;
    logic [31:0] a, base;
    int unsigned idx, tag;
    bit          hit;
    int          budget;
    a    = addr & 32'hFFFF_FFFC;
    idx  = (a / LINE_B) % LINES;
    tag  = a / (LINE_B * LINES);
    base = a - (a % LINE_B);
    ack_lat = lat;
    if (fl) foreach (mvalid[i]) mvalid[i] = 1'b0;
    hit = mvalid[idx] && (mtag[idx] == tag);
    it.we    = we;
    it.rdata = '0;
    it.cyc   = fl ? 1 : 0;
    if (we) begin
      m = '{we: 1'b1, addr: a, wdata: wd};
      exp_mem.push_back(m);
      ref_mem[a >> 2] = wd;
      it.cyc += lat + 1;
    end else begin
      if (!hit) begin
        mmiss = sat(mmiss);
        for (int k = 0; k < WORDS; k++) begin
          m = '{we: 1'b0, addr: base + 32'(4 * k), wdata: '0};
          exp_mem.push_back(m);
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
        it.cyc += WORDS * (lat + 1);
      end
      mhits = sat(mhits);
      it.cyc += 1;
      it.rdata = ref_rd(a);
    end
    it.hits   = mhits;
    it.misses = mmiss;
    exp_cpu.push_back(it);

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.flush     = fl;
    if (fl) begin
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.cpu_ready && budget < 400);
    check("cpu_ready_seen", bus.cpu_ready, 1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    repeat ($urandom_range(1, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  // Memory responder: acks after ack_lat request cycles and checks each request against the queue.
  initial begin
    int       cnt;
    bit       have;
    mem_exp_t cur;
    cnt  = 0;
    have = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (rst) begin
        cnt  = 0;
        have = 1'b0;
        continue;
      end
      if (bus.mem_req) begin
        cnt++;
        if (cnt == 1) begin
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_req", bus.mem_req, 0);
            have = 1'b0;
          end else begin
            cur  = exp_mem.pop_front();
            have = 1'b1;
          end
        end
        if (have)
          check("mem_txn", {bus.mem_we, bus.mem_addr, cur.we ? bus.mem_wdata : 32'h0},
                {cur.we, cur.addr, cur.wdata});
        if (cnt >= ack_lat) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) phys_mem[bus.mem_addr >> 2] = bus.mem_wdata;
          else            bus.mem_rdata = phys_rd(bus.mem_addr);
          cnt  = 0;
          have = 1'b0;
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 3) == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // CPU monitor: on each completed access pops the queue, checks latency/data, then counters a cycle later.
  initial begin
    int       wcyc;
    bit       cnt_pend;
    cpu_exp_t it, pend;
    wcyc     = 0;
    cnt_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_pend) begin
        check("hit_cnt", bus.hit_cnt, pend.hits);
        check("miss_cnt", bus.miss_cnt, pend.misses);
        cnt_pend = 1'b0;
      end
      if (rst) begin
        wcyc = 0;
        continue;
      end
      if (bus.cpu_ready && !bus.cpu_req) check("ready_without_req", bus.cpu_ready, 0);
      if (bus.cpu_req) begin
        wcyc++;
        if (bus.cpu_ready) begin
          if (exp_cpu.size() == 0) begin
            check("unexpected_cpu_ready", bus.cpu_ready, 0);
          end else begin
            it = exp_cpu.pop_front();
            check("access_latency", wcyc, it.cyc);
            if (!it.we) check("cpu_rdata", bus.cpu_rdata, it.rdata);
            pend     = it;
            cnt_pend = 1'b1;
          end
          wcyc = 0;
        end
      end else begin
        wcyc = 0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_hit_cnt", bus.hit_cnt, 0);
    check("rst_miss_cnt", bus.miss_cnt, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b0, 32'h4, '0, 1'b0, 2);              // miss, refill 0x0..0xC
    do_access(1'b0, 32'h8, '0, 1'b0, 2);              // hit
    do_access(1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0, 2);   // store hit
    do_access(1'b0, 32'h4, '0, 1'b0, 1);              // hit returns stored word
    do_access(1'b1, 32'h100, 32'h1234_5678, 1'b0, 3); // store miss, no allocate
    do_access(1'b0, 32'h100, '0, 1'b0, 1);            // miss, refill 0x100..0x10C
    for (int i = 0; i < 8; i++)
      do_access(1'b0, (i % 2 == 0) ? 32'h0 : 32'(LINE_B * LINES), '0, 1'b0, 1);
    do_access(1'b0, 32'h0, '0, 1'b1, 2);              // flush alongside a request
    do_access(1'b0, 32'h7, '0, 1'b0, 1);              // byte offset ignored, hits
    do_access(1'b0, 32'h4, '0, 1'b1, 3);

    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [31:0] addr;
      r    = $urandom_range(0, 99);
      addr = 32'($urandom_range(0, 3) * LINE_B * LINES + $urandom_range(0, LINES * WORDS - 1) * 4
                 + $urandom_range(0, 3));
      do_access(r < 30, addr, $urandom, r >= 95, $urandom_range(1, 3));
    end

    // Abort a refill with reset: the line must miss again afterwards.
    base    = 32'h2000;
    ack_lat = 3;
    for (int k = 0; k < WORDS; k++) exp_mem.push_back('{we: 1'b0, addr: base + 32'(4 * k), wdata: '0});
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = base;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("midrefill_rst_mem_req", bus.mem_req, 0);
    check("midrefill_rst_hit_cnt", bus.hit_cnt, 0);
    check("midrefill_rst_miss_cnt", bus.miss_cnt, 0);
    check("midrefill_rst_cpu_ready", bus.cpu_ready, 0);
    bus.cpu_req = 1'b0;
    exp_cpu.delete();
    exp_mem.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, base, '0, 1'b0, 2);
    do_access(1'b0, base + 32'h4, '0, 1'b0, 2);

    repeat (3) @(posedge clk);
    check("cpu_queue_drained", exp_cpu.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
